// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared float compare result codes, field view and stream FSM states
package fp_pkg;

  // Result of ordering x against y; noResult is reserved and never produced
  typedef enum logic [1:0] {
    xGTy     = 2'd0,
    xEQy     = 2'd1,
    xLTy     = 2'd2,
    noResult = 2'd3
  } compareResults;

  // Field view of an IEEE-754 single-precision word
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } ieee_t;

  // Frame accumulator states
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int FP_W = 32;

  // Split a raw 32-bit word into sign / exponent / mantissa
  function automatic ieee_t ieeeFormat(input logic [FP_W-1:0] bits);
    return ieee_t'(bits);
  endfunction

endpackage

// File: rtl/fp_stream_minmax_if.sv
// rtl/fp_stream_minmax_if.sv - element input stream and frame result bundle
interface fp_stream_minmax_if #(
  parameter int COUNT_W = 16
) ();

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_min;
  logic [31:0]        out_max;
  logic [COUNT_W-1:0] out_count;

  // Producer of elements and consumer of frame results
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_count
  );

  // The min/max block itself
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_count
  );

endinterface

// File: rtl/fp_stream_minmax_compare.sv
// rtl/fp_stream_minmax_compare.sv - sign-magnitude ordering of two float bit patterns
module compare
  import fp_pkg::*;
(
  input  logic [31:0]   i_x,
  input  logic [31:0]   i_y,
  output compareResults o_result
);

  ieee_t       w_x;
  ieee_t       w_y;
  logic [30:0] w_mag_x;
  logic [30:0] w_mag_y;
  logic        w_mag_gt;

  assign w_x      = ieeeFormat(i_x);
  assign w_y      = ieeeFormat(i_y);
  assign w_mag_x  = {w_x.exponent, w_x.mantissa};
  assign w_mag_y  = {w_y.exponent, w_y.mantissa};
  assign w_mag_gt = (w_mag_x > w_mag_y);

  // Order by sign first, then by raw magnitude (reversed for negatives); -0 sits below +0
  always_comb begin
    o_result = xEQy;
    if (i_x == i_y) begin
      o_result = xEQy;
    end else if (w_x.sign != w_y.sign) begin
      o_result = w_x.sign ? xLTy : xGTy;
    end else if (!w_x.sign) begin
      o_result = w_mag_gt ? xGTy : xLTy;
    end else begin
      o_result = w_mag_gt ? xLTy : xGTy;
    end
  end

endmodule

// File: rtl/fp_stream_minmax.sv
// rtl/fp_stream_minmax.sv - per-frame min, max and saturating element count of a float stream
module fp_stream_minmax
  import fp_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  fp_stream_minmax_if.slave bus
);

  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  state_t             r_state;
  logic [31:0]        r_min;
  logic [31:0]        r_max;
  logic [COUNT_W-1:0] r_count;
  logic               r_out_valid;

  logic               w_in_ready;
  logic               w_accept;
  compareResults      w_min_cmp;
  compareResults      w_max_cmp;

  // Incoming element against the running minimum
  compare u_cmp_min (
    .i_x      (bus.in_data),
    .i_y      (r_min),
    .o_result (w_min_cmp)
  );

  // Incoming element against the running maximum
  compare u_cmp_max (
    .i_x      (bus.in_data),
    .i_y      (r_max),
    .o_result (w_max_cmp)
  );

  // Ready follows the held state only; reset masks it so nothing looks acceptable mid-reset
  assign w_in_ready = ~reset & (r_state != ST_HOLD);
  assign w_accept   = bus.in_valid & w_in_ready;

  // Frame FSM: load on first element, fold later ones, present result until taken
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_min       <= '0;
      r_max       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_min   <= bus.in_data;
            r_max   <= bus.in_data;
            r_count <= COUNT_ONE;
            if (bus.in_last) begin
              r_state     <= ST_HOLD;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            // Strict compares keep the first occurrence on equal values
            if (w_min_cmp == xLTy) begin
              r_min <= bus.in_data;
            end
            if (w_max_cmp == xGTy) begin
              r_max <= bus.in_data;
            end
            if (r_count != COUNT_MAX) begin
              r_count <= r_count + COUNT_ONE;
            end
            if (bus.in_last) begin
              r_state     <= ST_HOLD;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_min   = r_min;
  assign bus.out_max   = r_max;
  assign bus.out_count = r_count;

endmodule

// File: tb/tb_fp_stream_minmax.sv
// tb/tb_fp_stream_minmax.sv - scoreboard bench for fp_stream_minmax against a numeric-key model
module tb_fp_stream_minmax;
  import fp_pkg::*;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  typedef struct {
    logic [31:0] mn;
    logic [31:0] mx;
    int          cnt;
  } res_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   rdy_mode = 0;
  logic rnd_rdy  = 1'b1;
  res_t exp_q[$];

  fp_stream_minmax_if #(.COUNT_W(CW)) bus ();

  fp_stream_minmax #(.COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.out_ready = (rdy_mode == 0) || ((rdy_mode == 1) && rnd_rdy);

  initial begin
    forever begin
      @(posedge clk);
      #1 rnd_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Map a float bit pattern onto a signed integer line: positives by magnitude,
  // negatives mirrored below them so that -0 lands just under +0.
  function automatic longint key(input logic [31:0] x);
    longint mag;
    mag = longint'({33'd0, x[30:0]});
    return x[31] ? (-mag - 1) : mag;
  endfunction

  function automatic res_t model(input logic [31:0] v[$]);
    res_t r;
    r.mn  = v[0];
    r.mx  = v[0];
    for (int i = 1; i < v.size(); i++) begin
      if (key(v[i]) < key(r.mn)) r.mn = v[i];
      if (key(v[i]) > key(r.mx)) r.mx = v[i];
    end
    r.cnt = (v.size() > SAT) ? SAT : v.size();
    return r;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 11))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h3F80_0000;
      3:       return 32'hBF80_0000;
      4:       return 32'h7F80_0000;
      5:       return 32'h7FC0_0001;
      6:       return 32'hFF80_0000;
      7:       return 32'h4000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic send_elem(input logic [31:0] d, input logic l);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
      n++;
    end
    chk("accept_wait", ok, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] v[$], input int gap);
    for (int i = 0; i < v.size(); i++) begin
      repeat ($urandom_range(gap, 0)) begin
        @(posedge clk);
        #1;
      end
      send_elem(v[i], (i == v.size() - 1));
    end
    exp_q.push_back(model(v));
    @(negedge clk);
    chk("latency_out_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_min", bus.out_min, 0);
    chk("rst_out_max", bus.out_max, 0);
    chk("rst_out_count", bus.out_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each newly presented result with the scoreboard head and
  // confirm it stays frozen, with input stalled, until the handshake.
  bit          have = 1'b0;
  logic [31:0] h_min;
  logic [31:0] h_max;
  int          h_cnt;

  always @(negedge clk) begin
    if (reset) begin
      have = 1'b0;
    end else if (bus.out_valid === 1'b1) begin
      chk("hold_in_ready", bus.in_ready, 0);
      if (!have) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("out_min", bus.out_min, e.mn);
          chk("out_max", bus.out_max, e.mx);
          chk("out_count", bus.out_count, e.cnt);
        end
        h_min = bus.out_min;
        h_max = bus.out_max;
        h_cnt = int'(bus.out_count);
        have  = 1'b1;
      end else begin
        chk("stable_min", bus.out_min, h_min);
        chk("stable_max", bus.out_max, h_max);
        chk("stable_count", bus.out_count, h_cnt);
      end
      if (bus.out_ready === 1'b1) have = 1'b0;
    end
  end

  initial begin
    logic [31:0] v[$];
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    do_reset();

    v.delete();
    v.push_back(32'h3F80_0000); v.push_back(32'hC040_0000);
    v.push_back(32'h4000_0000); v.push_back(32'h3F00_0000);
    send_frame(v, 0);

    v.delete();
    v.push_back(32'h3F80_0000);
    send_frame(v, 0);

    v.delete();
    v.push_back(32'h0000_0000); v.push_back(32'h8000_0000);
    send_frame(v, 1);

    v.delete();
    repeat (3) v.push_back(32'h4000_0000);
    send_frame(v, 1);

    // Back-pressure: result must hold while in_valid is driven and ignored
    rdy_mode = 2;
    v.delete();
    v.push_back(32'h3F80_0000); v.push_back(32'h4040_0000);
    send_frame(v, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    bus.in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("release_out_valid", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Abort a partial frame with reset; only the next frame may report
    send_elem(32'h4100_0000, 1'b0);
    send_elem(32'hC100_0000, 1'b0);
    do_reset();
    v.delete();
    v.push_back(32'h3F00_0000);
    send_frame(v, 0);

    // Counter saturation
    v.delete();
    for (int i = 0; i < 20; i++) v.push_back(rand_val());
    send_frame(v, 0);

    // Reset while a result is pending discards it
    rdy_mode = 2;
    v.delete();
    v.push_back(32'h4080_0000); v.push_back(32'h4090_0000);
    send_frame(v, 0);
    rdy_mode = 0;
    do_reset();

    // Randomized frames with input gaps and random out_ready
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      v.delete();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) v.push_back(rand_val());
      send_frame(v, 2);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_stream_minmax.md
FP_STREAM_MINMAX -- requirements
Module: fp_stream_minmax

Interface
REQ-001 Parameter COUNT_W, default 16, width of the element counter.
REQ-002 clk  input  1  rising-edge clock for the whole block.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  in_data/in_last carry a valid element.
REQ-005 in_ready  output  1  block can accept an element this cycle.
REQ-006 in_data  input  32  IEEE-754 single-precision element (sign, 8-bit biased exponent, 23-bit mantissa).
REQ-007 in_last  input  1  element is the final one of the current frame.
REQ-008 out_valid  output  1  frame result is presented.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_min  output  32  smallest element of the frame.
REQ-011 out_max  output  32  largest element of the frame.
REQ-012 out_count  output  COUNT_W  number of elements in the frame, saturating.

Function
REQ-013 An element SHALL be accepted on a rising edge only when in_valid and in_ready are both 1.
REQ-014 States SHALL be EMPTY (no element of the frame yet), ACCUM (at least one element held) and HOLD (result presented).
REQ-015 in_ready SHALL be 1 in EMPTY and ACCUM, and 0 in HOLD; it SHALL be registered-state driven only, with no combinational path from out_ready.
REQ-016 On accept in EMPTY, min and max SHALL both load in_data, count SHALL load 1, and the state SHALL go to ACCUM, or to HOLD if in_last=1.
REQ-017 On accept in ACCUM, min SHALL load in_data iff compare(in_data, min) = xLTy.
REQ-018 On accept in ACCUM, max SHALL load in_data iff compare(in_data, max) = xGTy.
REQ-019 On accept in ACCUM, count SHALL increment and saturate at 2^COUNT_W-1.
REQ-020 On accept in ACCUM, the state SHALL go to HOLD iff in_last=1.
REQ-021 Ordering SHALL be the sign-magnitude order of the compare stage: -0 (0x80000000) is below +0 (0x00000000), and NaN/Inf bit patterns are ordered by raw exponent/mantissa with no special handling.
REQ-022 On an equal compare (xEQy), the held value SHALL be kept (first occurrence wins).
REQ-023 out_valid SHALL be 1 exactly in HOLD, asserting on the cycle after the last element is accepted (1-cycle latency).
REQ-024 out_min, out_max and out_count SHALL be registers held stable throughout HOLD.
REQ-025 In HOLD with out_ready=1, the state SHALL go to EMPTY on the next edge; out_valid SHALL drop and in_ready SHALL rise on that edge, so there is no back-to-back accept in the same cycle.
REQ-026 In HOLD, in_valid SHALL be ignored and no element SHALL be consumed.
REQ-027 Outside HOLD, out_min, out_max and out_count SHALL be don't-care values to consumers but deterministic (the running values).

Reset
REQ-028 While reset=1, the state SHALL be EMPTY, out_valid=0, in_ready=0, out_min=0, out_max=0 and out_count=0.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 Reset mid-frame or in HOLD SHALL discard the partial or pending result without emitting it.
REQ-031 reset SHALL take priority over any simultaneous accept or out_ready.

Structure
REQ-032 Shared package fp_pkg SHALL hold the compareResults enum (xGTy=0, xEQy=1, xLTy=2, noResult=3) and the ieeeFormat helper function.
REQ-033 The existing compare module SHALL be instantiated twice (in_data vs min, in_data vs max) as the only sub-modules.
REQ-034 The FSM, registers and counter SHALL be local to fp_stream_minmax.

Verification
REQ-035 Stream 0x3F800000, 0xC0400000, 0x40000000, 0x3F000000(last) -> one cycle later out_valid=1, out_min=0xC0400000, out_max=0x40000000, out_count=4.
REQ-036 Single element 0x3F800000 with in_last=1 -> out_min=out_max=0x3F800000, out_count=1.
REQ-037 Hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 -> out_valid stays 1, outputs stay stable, in_ready=0, and nothing is consumed; out_ready=1 -> next cycle out_valid=0 and in_ready=1.
REQ-038 Stream 0x00000000, 0x80000000(last) -> out_min=0x80000000, out_max=0x00000000; a duplicate-value frame 0x40000000 x3 -> out_count=3 with min=max=0x40000000.
REQ-039 Assert reset after two accepted elements, then send 0x3F000000(last) -> out_min=out_max=0x3F000000, out_count=1, with no result emitted for the aborted frame.
REQ-040 With COUNT_W=4, send a 20-element frame -> out_count=15.
